m68k_intctrl: RTL and testbench

//  Parametrised, Wishbone-programmable interrupt controller for the m68k SoC.

---
 rtl/m68k_intc_pkg.sv | 21 ++
 rtl/m68k_intc_sync.sv | 43 ++++
 rtl/m68k_intctrl.sv | 178 +++++++++++++++++
 tb/tb_m68k_intctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/m68k_intc_pkg.sv
// Shared constants for the m68k interrupt controller: register map, spurious vector, IACK states.
package m68k_intc_pkg;

  localparam int MAX_SRC = 16;

  localparam logic [2:0] ADR_PEND  = 3'd0;
  localparam logic [2:0] ADR_MASK  = 3'd1;
  localparam logic [2:0] ADR_MODE  = 3'd2;
  localparam logic [2:0] ADR_LVL0  = 3'd3;
  localparam logic [2:0] ADR_LVL1  = 3'd4;
  localparam logic [2:0] ADR_VBASE = 3'd5;
  localparam logic [2:0] ADR_STAT  = 3'd6;

  localparam logic [7:0] SPURIOUS_VEC = 8'h18;

  typedef enum logic {
    IACK_IDLE = 1'b0,
    IACK_ACK  = 1'b1
  } iack_state_t;

endpackage

// File: rtl/m68k_intc_sync.sv
// Optional 2-flop synchroniser for a vector of interrupt lines, plus a rising-edge detector
// on the synchronised value.
module m68k_intc_sync #(
  parameter int W       = 8,
  parameter int SYNC_EN = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise
);

  logic [W-1:0] prev_p2;

  generate
    if (SYNC_EN != 0) begin : g_sync
      logic [W-1:0] meta_p0;
      logic [W-1:0] sync_p1;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          meta_p0 <= '0;
          sync_p1 <= '0;
        end else begin
          meta_p0 <= d;
          sync_p1 <= meta_p0;
        end
      end
      assign q = sync_p1;
    end else begin : g_direct
      assign q = d;
    end
  endgenerate

  // Edge stage: remember last synchronised value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_p2 <= '0;
    else        prev_p2 <= q;
  end

  assign rise = q & ~prev_p2;

endmodule

// File: rtl/m68k_intctrl.sv
// Wishbone-programmable 68k interrupt controller: per-source level/mask/mode, IPL output, IACK vectoring.
// Define M68K_INTC_VECTOR_EN for vectored acknowledges; otherwise every acknowledge is an autovector.
module m68k_intctrl
  import m68k_intc_pkg::*;
#(
  parameter int N_SRC   = 8,
  parameter int SYNC_EN = 1
) (
  input  logic             wb_clk_i,
  input  logic             wb_reset_ni,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic [2:0]       wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  output logic [31:0]      wb_dat_o,
  output logic             wb_ack_o,
  input  logic [N_SRC-1:0] int_i,
  output logic [2:0]       ipl_o,
  input  logic             iack_i,
  input  logic [2:0]       iack_lvl_i,
  output logic             iack_ack_o,
  output logic [7:0]       iack_vec_o,
  output logic             iack_avec_o
);

  logic [N_SRC-1:0] lvl_q, rise;
  logic [N_SRC-1:0] mask, mode, mode_nx, pend_edge, pend;
  logic [N_SRC-1:0] elig, w1c, iack_clr;
  logic [2:0]       lvl [N_SRC];
  logic [2:0]       win_lvl, lat_lvl;
  logic [3:0]       win_idx, win_idx_r, sel_idx;
  logic             sel_found;
  logic             acc, wr;
  logic [31:0]      rd_data;
  iack_state_t      state;
`ifdef M68K_INTC_VECTOR_EN
  logic [7:0]       vbase;
`endif
  logic             unused_dat;

  assign unused_dat = ^wb_dat_i;

  m68k_intc_sync #(.W(N_SRC), .SYNC_EN(SYNC_EN)) u_sync (
    .clk   (wb_clk_i),
    .rst_n (wb_reset_ni),
    .d     (int_i),
    .q     (lvl_q),
    .rise  (rise)
  );

  // A transfer is accepted only while ack is low, so back-to-back acks need a fresh strobe cycle
  assign acc     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr      = acc & wb_we_i;
  assign w1c     = (wr && wb_adr_i == ADR_PEND) ? wb_dat_i[N_SRC-1:0] : '0;
  assign mode_nx = (wr && wb_adr_i == ADR_MODE) ? wb_dat_i[N_SRC-1:0] : mode;
  assign pend    = (pend_edge & mode) | (lvl_q & ~mode);

  always_comb begin
    elig      = '0;
    win_lvl   = '0;
    win_idx   = '0;
    sel_found = 1'b0;
    sel_idx   = '0;
    iack_clr  = '0;
    for (int s = 0; s < N_SRC; s++) begin
      elig[s] = pend[s] & mask[s] & (lvl[s] != 3'd0);
      // Strict compare keeps the lowest index on a tie
      if (elig[s] && lvl[s] > win_lvl) begin
        win_lvl = lvl[s];
        win_idx = 4'(s);
      end
    end
    for (int s = N_SRC - 1; s >= 0; s--) begin
      if (elig[s] && lvl[s] == lat_lvl) begin
        sel_found = 1'b1;
        sel_idx   = 4'(s);
      end
    end
    for (int s = 0; s < N_SRC; s++) begin
      iack_clr[s] = (state == IACK_ACK) && sel_found && (sel_idx == 4'(s));
    end
  end

  always_comb begin
    rd_data = '0;
    case (wb_adr_i)
      ADR_PEND: rd_data[N_SRC-1:0] = pend;
      ADR_MASK: rd_data[N_SRC-1:0] = mask;
      ADR_MODE: rd_data[N_SRC-1:0] = mode;
      ADR_LVL0, ADR_LVL1: begin
        for (int s = 0; s < N_SRC; s++) begin
          if ((wb_adr_i == ADR_LVL0) == (s < 8)) rd_data[4*(s%8) +: 3] = lvl[s];
        end
      end
`ifdef M68K_INTC_VECTOR_EN
      ADR_VBASE: rd_data[7:0] = vbase;
`endif
      ADR_STAT: begin
        rd_data[2:0]  = ipl_o;
        rd_data[11:8] = win_idx_r;
      end
      default: rd_data = '0;
    endcase
  end

  // Bus stage: ack, read data and register-file writes
  always_ff @(posedge wb_clk_i or negedge wb_reset_ni) begin
    if (!wb_reset_ni) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      mask     <= '0;
      mode     <= '0;
      for (int s = 0; s < N_SRC; s++) lvl[s] <= '0;
`ifdef M68K_INTC_VECTOR_EN
      vbase    <= '0;
`endif
    end else begin
      wb_ack_o <= acc;
      if (acc) wb_dat_o <= rd_data;
      mode <= mode_nx;
      if (wr && wb_adr_i == ADR_MASK) mask <= wb_dat_i[N_SRC-1:0];
      for (int s = 0; s < N_SRC; s++) begin
        if (wr && ((wb_adr_i == ADR_LVL0 && s < 8) || (wb_adr_i == ADR_LVL1 && s >= 8)))
          lvl[s] <= wb_dat_i[4*(s%8) +: 3];
      end
`ifdef M68K_INTC_VECTOR_EN
      if (wr && wb_adr_i == ADR_VBASE) vbase <= wb_dat_i[7:0];
`endif
    end
  end

  // Pending stage: a new edge beats any clear in the same cycle; a mode change drops the edge bit
  always_ff @(posedge wb_clk_i or negedge wb_reset_ni) begin
    if (!wb_reset_ni) begin
      pend_edge <= '0;
      ipl_o     <= '0;
      win_idx_r <= '0;
    end else begin
      pend_edge <= ((pend_edge & ~(w1c | iack_clr | (mode ^ mode_nx))) | rise) & mode_nx;
      ipl_o     <= win_lvl;
      win_idx_r <= win_idx;
    end
  end

  // Acknowledge stage
  always_ff @(posedge wb_clk_i or negedge wb_reset_ni) begin
    if (!wb_reset_ni) begin
      state       <= IACK_IDLE;
      lat_lvl     <= '0;
      iack_ack_o  <= 1'b0;
      iack_vec_o  <= '0;
      iack_avec_o <= 1'b0;
    end else begin
      case (state)
        IACK_IDLE: begin
          iack_ack_o <= 1'b0;
          if (iack_i) begin
            lat_lvl <= iack_lvl_i;
            state   <= IACK_ACK;
          end
        end
        default: begin
          iack_ack_o <= 1'b1;
          state      <= IACK_IDLE;
`ifdef M68K_INTC_VECTOR_EN
          iack_vec_o  <= sel_found ? (vbase + {4'b0000, sel_idx}) : SPURIOUS_VEC;
          iack_avec_o <= 1'b0;
`else
          iack_vec_o  <= '0;
          iack_avec_o <= 1'b1;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m68k_intctrl.sv
// Directed self-checking bench for m68k_intctrl (N_SRC=8, SYNC_EN=1), vectored or autovector build.
module tb_m68k_intctrl;
  import m68k_intc_pkg::*;

`ifdef M68K_INTC_VECTOR_EN
  localparam bit VEC_EN = 1'b1;
`else
  localparam bit VEC_EN = 1'b0;
`endif

  logic        wb_clk_i = 1'b0;
  logic        wb_reset_ni = 1'b0;
  logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [2:0]  wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic [7:0]  int_i = '0;
  logic [2:0]  ipl_o;
  logic        iack_i = 1'b0;
  logic [2:0]  iack_lvl_i = '0;
  logic        iack_ack_o;
  logic [7:0]  iack_vec_o;
  logic        iack_avec_o;

  int tests = 0;
  int fails = 0;

  m68k_intctrl #(.N_SRC(8), .SYNC_EN(1)) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_reset_ni (wb_reset_ni),
    .wb_cyc_i    (wb_cyc_i),
    .wb_stb_i    (wb_stb_i),
    .wb_we_i     (wb_we_i),
    .wb_adr_i    (wb_adr_i),
    .wb_dat_i    (wb_dat_i),
    .wb_dat_o    (wb_dat_o),
    .wb_ack_o    (wb_ack_o),
    .int_i       (int_i),
    .ipl_o       (ipl_o),
    .iack_i      (iack_i),
    .iack_lvl_i  (iack_lvl_i),
    .iack_ack_o  (iack_ack_o),
    .iack_vec_o  (iack_vec_o),
    .iack_avec_o (iack_avec_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [31:0] d, input string tag);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = a; wb_dat_i = d;
    @(posedge wb_clk_i); #1;
    chk({tag, " ack"}, 32'(wb_ack_o), 32'd1);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(posedge wb_clk_i); #1;
    chk({tag, " ack drop"}, 32'(wb_ack_o), 32'd0);
  endtask

  task automatic wb_read_chk(input logic [2:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] d;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = a;
    @(posedge wb_clk_i); #1;
    d = wb_dat_o;
    chk({tag, " rd ack"}, 32'(wb_ack_o), 32'd1);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    chk(tag, d, exp);
    @(posedge wb_clk_i); #1;
  endtask

  task automatic do_iack(input logic [2:0] l, input logic [7:0] v, input string tag);
    iack_i = 1'b1; iack_lvl_i = l;
    @(posedge wb_clk_i); #1;
    iack_i = 1'b0;
    chk({tag, " early"}, 32'(iack_ack_o), 32'd0);
    @(posedge wb_clk_i); #1;
    chk({tag, " ack"}, 32'(iack_ack_o), 32'd1);
    chk({tag, " vec"}, 32'(iack_vec_o), VEC_EN ? 32'(v) : 32'd0);
    chk({tag, " avec"}, 32'(iack_avec_o), VEC_EN ? 32'd0 : 32'd1);
    @(posedge wb_clk_i); #1;
    chk({tag, " ack end"}, 32'(iack_ack_o), 32'd0);
  endtask

  initial begin
    // Reset state
    cycles(3);
    chk("rst ipl", 32'(ipl_o), 32'd0);
    chk("rst wb_ack", 32'(wb_ack_o), 32'd0);
    wb_reset_ni = 1'b1;
    cycles(1);
    chk("rst iack_ack", 32'(iack_ack_o), 32'd0);
    chk("rst iack_vec", 32'(iack_vec_o), 32'd0);
    for (int a = 0; a < 8; a++) wb_read_chk(3'(a), 32'd0, $sformatf("rst reg%0d", a));

    wb_write(ADR_MASK, 32'hFF, "mask wr");
    wb_read_chk(ADR_MASK, 32'hFF, "mask rd");
    wb_write(ADR_STAT, 32'hFFFF_FFFF, "stat wr");
    wb_read_chk(ADR_STAT, 32'd0, "stat ro");

    // Priority: src2 lvl3, src5 lvl6, level mode
    wb_write(ADR_LVL0, 32'h0060_0300, "lvl0 wr");
    wb_read_chk(ADR_LVL0, 32'h0060_0300, "lvl0 rd");
    int_i = 8'h24;
    cycles(4);
    chk("prio ipl6", 32'(ipl_o), 32'd6);
    wb_read_chk(ADR_STAT, 32'h0000_0506, "prio stat");
    int_i = 8'h04;
    cycles(4);
    chk("prio ipl3", 32'(ipl_o), 32'd3);
    wb_read_chk(ADR_STAT, 32'h0000_0203, "prio stat2");
    int_i = 8'h00;
    cycles(4);
    chk("prio ipl0", 32'(ipl_o), 32'd0);

    // Tie: src1 and src4 at lvl5, VBASE 0x40
    wb_write(ADR_LVL0, 32'h0005_0050, "tie lvl");
    wb_write(ADR_VBASE, 32'h40, "vbase wr");
    wb_read_chk(ADR_VBASE, VEC_EN ? 32'h40 : 32'h0, "vbase rd");
    int_i = 8'h12;
    cycles(4);
    chk("tie ipl", 32'(ipl_o), 32'd5);
    wb_read_chk(ADR_STAT, 32'h0000_0105, "tie stat");
    do_iack(3'd5, 8'h41, "tie iack");
    chk("tie level stays", 32'(ipl_o), 32'd5);
    int_i = 8'h00;
    cycles(4);

    // Edge: src3 edge mode, lvl2
    wb_write(ADR_MODE, 32'h08, "mode wr");
    wb_write(ADR_LVL0, 32'h0000_2000, "edge lvl");
    int_i = 8'h08;
    cycles(1);
    int_i = 8'h00;
    cycles(5);
    wb_read_chk(ADR_PEND, 32'h08, "edge pend set");
    chk("edge ipl", 32'(ipl_o), 32'd2);
    do_iack(3'd2, 8'h43, "edge iack");
    wb_read_chk(ADR_PEND, 32'h00, "edge pend clr");
    chk("edge ipl0", 32'(ipl_o), 32'd0);

    // New edge in the same cycle as W1C: set wins
    int_i = 8'h08;
    cycles(2);
    wb_write(ADR_PEND, 32'h08, "w1c race");
    wb_read_chk(ADR_PEND, 32'h08, "w1c race pend");
    wb_write(ADR_PEND, 32'h08, "w1c plain");
    wb_read_chk(ADR_PEND, 32'h00, "w1c plain pend");

    // Spurious: nothing at level 4
    int_i = 8'h00;
    cycles(3);
    int_i = 8'h08;
    cycles(1);
    int_i = 8'h00;
    cycles(5);
    wb_read_chk(ADR_PEND, 32'h08, "spur pend pre");
    do_iack(3'd4, SPURIOUS_VEC, "spur iack");
    wb_read_chk(ADR_PEND, 32'h08, "spur pend post");
    chk("spur ipl", 32'(ipl_o), 32'd2);

    // Mode switch drops the edge-pending bit
    wb_write(ADR_MODE, 32'h00, "mode lvl");
    wb_read_chk(ADR_PEND, 32'h00, "mode lvl pend");
    wb_write(ADR_MODE, 32'h08, "mode edge");
    wb_read_chk(ADR_PEND, 32'h00, "mode edge pend");

    // Reset during the ACK state
    int_i = 8'h08;
    cycles(1);
    int_i = 8'h00;
    cycles(5);
    wb_read_chk(ADR_PEND, 32'h08, "midrst pend");
    iack_i = 1'b1; iack_lvl_i = 3'd2;
    @(posedge wb_clk_i); #1;
    iack_i = 1'b0;
    wb_reset_ni = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycles(1);
      chk($sformatf("midrst no ack %0d", i), 32'(iack_ack_o), 32'd0);
    end
    wb_reset_ni = 1'b1;
    cycles(2);
    chk("midrst ack after", 32'(iack_ack_o), 32'd0);
    chk("midrst ipl", 32'(ipl_o), 32'd0);
    wb_read_chk(ADR_PEND, 32'h00, "midrst pend clr");
    wb_read_chk(ADR_MASK, 32'h00, "midrst mask");
    wb_read_chk(ADR_MODE, 32'h00, "midrst mode");
    wb_read_chk(ADR_LVL0, 32'h00, "midrst lvl0");
    wb_read_chk(ADR_VBASE, 32'h00, "midrst vbase");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
